// File: rtl/band_energy_if.sv
// Streaming interface for band_energy_accumulator: sample input handshake,
// frame abort, and the result bundle with its valid/ready handshake.
interface band_energy_if #(
    parameter int DIN_W     = 31,
    parameter int ACC_W     = 31,
    parameter int NUM_BANDS = 11
);
    logic [DIN_W-1:0]           din;
    logic                       in_valid;
    logic                       in_ready;
    logic                       clr;
    logic [NUM_BANDS*ACC_W-1:0] band_out;
    logic [ACC_W-1:0]           total_out;
    logic [NUM_BANDS:0]         sat_flags;
    logic                       out_valid;
    logic                       out_ready;

    // Producer/consumer side: feeds samples and drains results.
    modport master (
        output din, in_valid, clr, out_ready,
        input  in_ready, band_out, total_out, sat_flags, out_valid
    );

    // Accumulator side.
    modport slave (
        input  din, in_valid, clr, out_ready,
        output in_ready, band_out, total_out, sat_flags, out_valid
    );
endinterface

// File: rtl/band_energy_accumulator.sv
// Band energy accumulator: sums per-bin magnitudes of a frame into a set of
// overlapping bands plus a total over the covered bin range. Samples may
// arrive in bit-reversed bin order (FFT output order). Results of a frame are
// published with a valid/ready handshake and are never overwritten before the
// consumer takes them.
module band_energy_accumulator #(
    parameter int DIN_W     = 31,
    parameter int ACC_W     = 31,
    parameter int FRAME_LEN = 128,
    parameter int NUM_BANDS = 11,
    parameter int BAND_SPAN = 3,
    parameter int BAND_STEP = 1,
    parameter int BIN0      = 0,
    parameter int BITREV    = 1
) (
    input logic         clk,
    input logic         rst_n,
    band_energy_if.slave bus
);

    localparam int CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TOT_SPAN = (NUM_BANDS - 1) * BAND_STEP + BAND_SPAN;

    // Add a sample to an accumulator, clamping at full scale. The MSB of the
    // result reports that the clamp was applied.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [DIN_W-1:0] d);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(d);
        if (s[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return s;
    endfunction

    // Mirror the counter bits to recover the natural bin index.
    function automatic logic [CNT_W-1:0] bit_rev(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        for (int i = 0; i < CNT_W; i++)
            r[i] = v[CNT_W-1-i];
        return r;
    endfunction

    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           k;
    logic [31:0]                k32;
    logic                       last;
    logic                       ready;
    logic                       take;

    logic [ACC_W-1:0]           acc [NUM_BANDS];
    logic [ACC_W-1:0]           acc_tot;
    logic [NUM_BANDS-1:0]       flg;
    logic                       flg_tot;

    logic [NUM_BANDS-1:0]       hit;
    logic                       hit_tot;
    logic [ACC_W:0]             band_nx [NUM_BANDS];
    logic [ACC_W:0]             tot_nx;
    logic [NUM_BANDS-1:0]       band_ovf;
    logic                       tot_ovf;
    logic [NUM_BANDS*ACC_W-1:0] band_vec;

    logic [NUM_BANDS*ACC_W-1:0] band_q;
    logic [ACC_W-1:0]           total_q;
    logic [NUM_BANDS:0]         sat_q;
    logic                       out_valid_q;

    assign k    = (BITREV != 0) ? bit_rev(cnt) : cnt;
    assign k32  = 32'(k);
    assign last = (cnt == CNT_W'(FRAME_LEN - 1));

    // Only the frame-closing sample can be blocked: it would overwrite results
    // the consumer has not taken yet.
    assign ready = !(last && out_valid_q && !bus.out_ready);
    // A sample presented together with a frame abort is dropped.
    assign take  = bus.in_valid && ready && !bus.clr;

    // Range checks use unsigned wrap-around: k below the band start wraps to
    // a huge value and fails the span compare.
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        localparam int LO = BIN0 + b * BAND_STEP;
        assign hit[b]      = (k32 - 32'(LO)) < 32'(BAND_SPAN);
        assign band_nx[b]  = hit[b] ? sat_add(acc[b], bus.din) : {1'b0, acc[b]};
        assign band_ovf[b] = band_nx[b][ACC_W];
        assign band_vec[b*ACC_W +: ACC_W] = band_nx[b][ACC_W-1:0];
    end

    assign hit_tot = (k32 - 32'(BIN0)) < 32'(TOT_SPAN);
    assign tot_nx  = hit_tot ? sat_add(acc_tot, bus.din) : {1'b0, acc_tot};
    assign tot_ovf = tot_nx[ACC_W];

    // Running frame state: bin counter, band/total accumulators, sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc_tot <= '0;
            flg     <= '0;
            flg_tot <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++)
                acc[b] <= '0;
        end else if (bus.clr || (take && last)) begin
            cnt     <= '0;
            acc_tot <= '0;
            flg     <= '0;
            flg_tot <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++)
                acc[b] <= '0;
        end else if (take) begin
            cnt     <= cnt + 1'b1;
            acc_tot <= tot_nx[ACC_W-1:0];
            flg     <= flg | band_ovf;
            flg_tot <= flg_tot | tot_ovf;
            for (int b = 0; b < NUM_BANDS; b++)
                acc[b] <= band_nx[b][ACC_W-1:0];
        end
    end

    // Result registers: load on frame completion, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_q      <= '0;
            total_q     <= '0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (take && last) begin
            band_q      <= band_vec;
            total_q     <= tot_nx[ACC_W-1:0];
            sat_q       <= {flg_tot | tot_ovf, flg | band_ovf};
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.band_out  = band_q;
    assign bus.total_out = total_q;
    assign bus.sat_flags = sat_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: doc/band_energy_accumulator.md
BAND_ENERGY_ACCUMULATOR -- requirements
Module: band_energy_accumulator

Interface
REQ-001 Parameter DIN_W, 31, input sample width (unsigned magnitude).
REQ-002 Parameter ACC_W, 31, accumulator and result width, ACC_W >= DIN_W.
REQ-003 Parameter FRAME_LEN, 128, samples per frame, power of two when BITREV=1.
REQ-004 Parameter NUM_BANDS, 11, number of overlapping bands.
REQ-005 Parameter BAND_SPAN, 3, bins summed per band.
REQ-006 Parameter BAND_STEP, 1, bin offset between consecutive band starts.
REQ-007 Parameter BIN0, 0, first bin of band 0.
REQ-008 Parameter BITREV, 1, 1 = samples arrive in bit-reversed bin order; 0 = natural order.
REQ-009 clk  in  1  sole clock, all state on rising edge.
REQ-010 rst_n  in  1  asynchronous, active-low reset.
REQ-011 din  in  DIN_W  sample value.
REQ-012 in_valid  in  1  din valid this cycle.
REQ-013 in_ready  out  1  block accepts din this cycle.
REQ-014 clr  in  1  synchronous frame abort.
REQ-015 band_out  out  NUM_BANDS*ACC_W  band results, band b at bits [b*ACC_W +: ACC_W].
REQ-016 total_out  out  ACC_W  sum over all covered bins.
REQ-017 sat_flags  out  NUM_BANDS+1  per-band saturation flags, bit NUM_BANDS = total.
REQ-018 out_valid  out  1  results valid, held until consumed.
REQ-019 out_ready  in  1  consumer accepts results.

Function
REQ-020 Sample accepted on a rising edge where in_valid && in_ready.
REQ-021 Frame counter cnt ($clog2(FRAME_LEN) bits) increments per accepted sample and wraps FRAME_LEN-1 -> 0.
REQ-022 Bin index k = bit-reverse(cnt) when BITREV=1, else k = cnt.
REQ-023 Band b accumulates din when BIN0+b*BAND_STEP <= k <= BIN0+b*BAND_STEP+BAND_SPAN-1; bins may belong to several bands.
REQ-024 Total accumulates din when BIN0 <= k <= BIN0+(NUM_BANDS-1)*BAND_STEP+BAND_SPAN-1.
REQ-025 Accumulation is on the accepting edge, no input pipeline stage.
REQ-026 Additions saturate at 2^ACC_W-1; saturating accumulator sets its flag for the rest of the frame.
REQ-027 On accepting sample cnt=FRAME_LEN-1, the same edge loads band_out, total_out, sat_flags with final values (including that sample), sets out_valid, clears accumulators, flags and cnt.
REQ-028 out_valid clears on an edge with out_valid && out_ready and no simultaneous frame completion; completion with out_ready=1 reloads and keeps out_valid=1.
REQ-029 in_ready = !(cnt==FRAME_LEN-1 && out_valid && !out_ready); all other cycles in_ready=1; unconsumed results never overwritten.
REQ-030 Outputs hold value while out_valid=0 or out_ready=0.
REQ-031 clr=1: next edge zeros cnt, accumulators, running flags; band_out, total_out, sat_flags, out_valid untouched; a sample presented with clr is discarded.
REQ-032 Bins outside every band and the total range are counted but not accumulated.

Reset
REQ-033 rst_n low: immediately zero cnt, accumulators, band_out, total_out, sat_flags, out_valid; in_ready=1 after release.
REQ-034 rst_n mid-frame discards the partial frame; first sample after release is cnt=0.

Verification
REQ-035 Defaults, din=1 for 128 samples, out_ready=1 -> after sample 128 edge: out_valid=1 one cycle, every band=3, total=13, sat_flags=0.
REQ-036 BITREV=0, din=cnt, 128 samples -> band0=3, band10=33, total=78.
REQ-037 out_ready=0 across two frames -> in_ready=0 at second frame's last sample, first results held; raise out_ready -> sample accepted, second frame results loaded, out_valid stays 1.
REQ-038 ACC_W=8, DIN_W=8, din=200 every sample -> each band=255, total=255, sat_flags all 1.
REQ-039 rst_n low at sample 50, then full frame din=2 -> outputs zero during reset; result bands=6, total=26.
REQ-040 clr at sample 20, then full frame din=1 -> previous out values unchanged until new frame; new bands=3, total=13.
